// File: rtl/cpu_run_ctrl.sv
// Run controller for the processor top.
// Generates a staged, synchronously released reset for the core sub-blocks.
// Drives a registered clock enable with free-run, halt and single-step modes.
// Counts enabled cycles and stops permanently on a halt instruction or when the
// cycle budget runs out.
module cpu_run_ctrl #(
  parameter int unsigned N_RST     = 3,
  parameter int unsigned STAGE_DLY = 2,
  parameter int unsigned CYC_W     = 32,
  parameter int unsigned MAX_CYC   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_mode,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             halt_instr,
  output logic [N_RST-1:0] rst_out,
  output logic             cpu_en,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic [2:0]       state,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned    SeqMax  = N_RST * STAGE_DLY;
  localparam int unsigned    SeqW    = $clog2(SeqMax + 1);
  localparam logic [SeqW-1:0] SeqEnd = SeqW'(SeqMax);
  // Only used when MAX_CYC is non-zero.
  localparam logic [CYC_W-1:0] CycLast = CYC_W'(MAX_CYC - 1);
  localparam logic [CYC_W-1:0] CycSat  = '1;

  localparam logic [2:0] StSeq  = 3'd0;
  localparam logic [2:0] StHalt = 3'd1;
  localparam logic [2:0] StRun  = 3'd2;
  localparam logic [2:0] StStep = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [1:0]       sync_q;
  logic [SeqW-1:0]  seq_cnt_q, seq_cnt_d;
  logic [N_RST-1:0] rst_out_q, rst_out_d;
  logic [2:0]       state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             seq_last;

  // Two-flop release synchroniser; cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  // Saturating sequence counter and staged reset outputs derived from it.
  always_comb begin
    seq_cnt_d = seq_cnt_q;
    if (sync_q[1] && (seq_cnt_q != SeqEnd)) begin
      seq_cnt_d = seq_cnt_q + SeqW'(1);
    end
    rst_out_d = '0;
    for (int unsigned i = 0; i < N_RST; i++) begin
      rst_out_d[i] = (seq_cnt_d < SeqW'((i + 1) * STAGE_DLY));
    end
    seq_last = (seq_cnt_d == SeqEnd);
  end

  // Run-state next-state logic, enabled-cycle counting and stop detection.
  always_comb begin
    state_d   = state_q;
    cpu_en_d  = cpu_en_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    case (state_q)
      StSeq: begin
        // Leaves on the edge where the last reset stage falls.
        if (seq_last) begin
          state_d  = run_mode ? StRun : StHalt;
          cpu_en_d = run_mode;
        end
      end
      StHalt: begin
        cpu_en_d = 1'b0;
        if (!halt_req) begin
          if (run_req) begin
            state_d  = StRun;
            cpu_en_d = 1'b1;
          end else if (step_req) begin
            state_d  = StStep;
            cpu_en_d = 1'b1;
          end
        end
      end
      StRun, StStep: begin
        cnt_d = (cnt_q == CycSat) ? cnt_q : cnt_q + CYC_W'(1);
        // Stop conditions outrank halt_req; halt_instr outranks the budget.
        if (halt_instr) begin
          state_d  = StDone;
          cpu_en_d = 1'b0;
          done_d   = 1'b1;
        end else if ((MAX_CYC != 0) && (cnt_q == CycLast)) begin
          state_d   = StDone;
          cpu_en_d  = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else if ((state_q == StStep) || halt_req) begin
          state_d  = StHalt;
          cpu_en_d = 1'b0;
        end
      end
      StDone: begin
        cpu_en_d = 1'b0;
      end
      default: begin
        state_d  = StHalt;
        cpu_en_d = 1'b0;
      end
    endcase
  end

  // State registers; reset applies asynchronously in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_cnt_q <= '0;
      rst_out_q <= '1;
      state_q   <= StSeq;
      cpu_en_q  <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      seq_cnt_q <= seq_cnt_d;
      rst_out_q <= rst_out_d;
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign cpu_en    = cpu_en_q;
  assign cycle_cnt = cnt_q;
  assign state     = state_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the processor top. It generates a staged, synchronously released reset for N processor sub-blocks (memories, register file, PC) and drives a registered clock enable, `cpu_en`, into the core. The enable supports free-run, halt and single-step modes. The block counts enabled cycles and stops the core on a halt instruction or on a cycle budget. Simulation benches and the FPGA wrapper instantiate it between the board clock/reset and `top`.

## Interface
- `N_RST`, default 3: number of staged reset outputs; minimum 1.
- `STAGE_DLY`, default 2: cycles between successive reset releases; minimum 1.
- `CYC_W`, default 32: width of the enabled-cycle counter.
- `MAX_CYC`, default 0: cycle budget.
  - 0 means unlimited.
  - Otherwise it must satisfy 1 ≤ MAX_CYC < 2^CYC_W.

Ports:
- `clk`  in  1  system clock; all flops on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion is asynchronous; release is synchronised internally.
- `run_mode`  in  1  state entered after the reset sequence: 1 = RUN, 0 = HALT. Sampled on the release edge.
- `run_req`  in  1  level; HALT → RUN.
- `halt_req`  in  1  level; RUN → HALT.
- `step_req`  in  1  level; HALT → STEP, giving one enabled cycle.
- `halt_instr`  in  1  core is executing its halt instruction. Meaningful only while `cpu_en`=1.
- `rst_out`  out  N_RST  active-high resets to the core sub-blocks. Bit i releases after bit i-1.
- `cpu_en`  out  1  registered clock enable to the core.
- `cycle_cnt`  out  CYC_W  number of completed enabled cycles.
- `state`  out  3  current state: SEQ=0, HALT=1, RUN=2, STEP=3, DONE=4.
- `done`  out  1  sticky; core stopped permanently.
- `timeout`  out  1  sticky; the stop was caused by MAX_CYC.

## Operation
- **Reset values** (while `rst`=0, applied asynchronously): `rst_out`=all ones, `cpu_en`=0, `cycle_cnt`=0, `state`=SEQ, `done`=0, `timeout`=0. The synchroniser and the sequence counter are also cleared.
- **Release synchroniser:** two flops clocked by `clk`, asynchronously cleared by `rst`.
- **SEQ:**
  - The sequence counter `seq_cnt` increments on every edge once the synchroniser output is 1.
  - `rst_out[i]` = 1 while `seq_cnt` < (i+1)·STAGE_DLY.
  - `seq_cnt` saturates at N_RST·STAGE_DLY; its width is clog2(N_RST·STAGE_DLY+1).
  - On the edge where `rst_out[N_RST-1]` falls, `state` becomes RUN with `cpu_en`←1 if `run_mode`=1, otherwise HALT with `cpu_en`←0.
- **RUN:**
  - `cpu_en` stays 1.
  - `halt_req`=1 → HALT and `cpu_en`←0.
  - `run_req` and `step_req` are ignored.
- **HALT:**
  - `cpu_en`=0.
  - `halt_req`=1 → stay in HALT. `halt_req` overrides `run_req` and `step_req`.
  - Otherwise `run_req`=1 → RUN and `cpu_en`←1.
  - Otherwise `step_req`=1 → STEP and `cpu_en`←1.
- **STEP:**
  - Lasts exactly one cycle; `cpu_en`=1 during it.
  - The next edge returns to HALT with `cpu_en`←0, regardless of the request inputs.
  - A held `step_req` therefore produces one enabled cycle every 2 cycles.
- **Edges where `cpu_en`=1** (RUN or STEP):
  - `cycle_cnt` increments. It saturates at all ones when MAX_CYC=0; it never wraps.
  - If `halt_instr`=1: → DONE, `cpu_en`←0, `done`←1.
  - Else if MAX_CYC≠0 and `cycle_cnt`==MAX_CYC-1: → DONE, `cpu_en`←0, `done`←1, `timeout`←1.
  - Both checks take priority over `halt_req`. When `halt_instr` and the budget hit coincide, `halt_instr` wins and `timeout` stays 0.
- **DONE:** `cpu_en`=0; all request inputs are ignored. Only `rst` exits this state.
- **Reset mid-operation:** asserting `rst` in any state, including mid-STEP or mid-SEQ, immediately applies the reset values. The full staged sequence then restarts.

## Timing
- Let E1 be the first rising edge with `rst`=1. The synchroniser output is 1 after E2, and `seq_cnt` counts from E3.
- `rst_out[i]` falls at edge E(2+(i+1)·STAGE_DLY).
  - Defaults: bit 0 at E4, bit 1 at E6, bit 2 at E8.
  - `cpu_en` rises at E8 when `run_mode`=1.
- The halt paths (`halt_req`, `run_req`, `step_req`) have one-edge latency: a request seen at edge E changes `cpu_en` from edge E.
- The enabled cycle in which `halt_instr` is seen is counted. `cpu_en` is 0 after that edge.
- With MAX_CYC=M, exactly M enabled cycles occur before `done`.

## Test plan
- **Default parameters, `run_mode`=1, `rst` released:** `rst_out` goes 111→110 at E4, →100 at E6, →000 at E8; `cpu_en`=1 from E8; `state`=2.
- **RUN, `halt_req` pulsed at cycle-count 10, then `run_req`:** `cpu_en` drops for the halt window; `cycle_cnt` freezes at 10 or 11 as seen at the halt edge; counting resumes after `run_req`.
- **`run_mode`=0, `step_req` held 6 cycles:** exactly 3 enabled cycles; `cycle_cnt`=3; `state` alternates 1/3.
- **MAX_CYC=5, free run:**
  - Free run: `cycle_cnt`=5, `done`=1, `timeout`=1, `state`=4; `run_req` is then ignored.
  - Same run with `halt_instr` on the 5th enabled cycle: `done`=1, `timeout`=0.
- **`rst` asserted during STEP, then released:** all outputs return to reset values immediately; the full staged release repeats exactly as in the first scenario.
